// File: rtl/decoder_nto2n_seq.sv
// N-to-2^N one-hot decoder with registered output, direct and scan modes.
// Define DEC_ACTIVE_LOW_EN to drive D active-low (all ones when inactive).
module decoder_nto2n_seq #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      A,
    input  logic              a_valid,
    input  logic [N-1:0]      last,
    output logic [2**N-1:0]   D,
    output logic              d_valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [W-1:0]  ONE_W    = W'(1);
    localparam logic [N-1:0]  ONE_N    = N'(1);
    localparam logic [DW-1:0] ONE_DW   = DW'(1);
    localparam logic [DW-1:0] DWELL_M1 = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t        state;
    logic [W-1:0]  sel;
    logic [DW-1:0] dwell;
    logic [N-1:0]  last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            d_valid <= 1'b0;
            idx     <= '0;
            wrap    <= 1'b0;
            dwell   <= '0;
            last_q  <= '0;
        end else if (!en) begin
            state   <= IDLE;
            sel     <= '0;
            d_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (!mode) begin
            state <= DIRECT;
            wrap  <= 1'b0;
            if (a_valid) begin
                sel     <= ONE_W << A;
                idx     <= A;
                d_valid <= 1'b1;
            end
        end else if (state != SCAN) begin
            // Scan always restarts from index 0, never resumes
            state   <= SCAN;
            sel     <= ONE_W;
            d_valid <= 1'b1;
            idx     <= '0;
            wrap    <= 1'b0;
            dwell   <= '0;
            last_q  <= last;
        end else if (dwell == DWELL_M1) begin
            dwell <= '0;
            if (idx == last_q) begin
                // Wrap is checked before increment, so idx never overflows
                idx    <= '0;
                sel    <= ONE_W;
                wrap   <= 1'b1;
                last_q <= last;
            end else begin
                idx  <= idx + ONE_N;
                sel  <= sel << 1;
                wrap <= 1'b0;
            end
        end else begin
            dwell <= dwell + ONE_DW;
            wrap  <= 1'b0;
        end
    end

`ifdef DEC_ACTIVE_LOW_EN
    assign D = ~sel;
`else
    assign D = sel;
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Randomised + directed bench for decoder_nto2n_seq; two instances (DWELL=4, DWELL=1)
// share stimulus and are compared each cycle against a cycle-count reference model.
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, a_valid;
    logic [2:0] A, last;

    logic [7:0] d_o   [2];
    logic       dv_o  [2];
    logic [2:0] idx_o [2];
    logic       wr_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.N(3), .DWELL(4)) u_dw4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A), .a_valid(a_valid),
        .last(last), .D(d_o[0]), .d_valid(dv_o[0]), .idx(idx_o[0]), .wrap(wr_o[0])
    );

    decoder_nto2n_seq #(.N(3), .DWELL(1)) u_dw1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A), .a_valid(a_valid),
        .last(last), .D(d_o[1]), .d_valid(dv_o[1]), .idx(idx_o[1]), .wrap(wr_o[1])
    );

    // Reference model: scan position is a tick count since the last (re)start
    int dw   [2] = '{4, 1};
    int m_st [2];   // 0 idle, 1 direct, 2 scan
    int m_t  [2];
    int m_ln [2];
    int m_idx[2];
    bit m_on [2];
    bit m_dv [2];
    bit m_wr [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i] = 0; m_t[i] = 0; m_ln[i] = 0; m_idx[i] = 0;
                m_on[i] = 0; m_dv[i] = 0; m_wr[i] = 0;
            end else if (!en) begin
                m_st[i] = 0; m_on[i] = 0; m_dv[i] = 0; m_wr[i] = 0;
            end else if (!mode) begin
                m_st[i] = 1; m_wr[i] = 0;
                if (a_valid) begin
                    m_idx[i] = int'(A); m_on[i] = 1; m_dv[i] = 1;
                end
            end else if (m_st[i] != 2) begin
                m_st[i] = 2; m_t[i] = 0; m_ln[i] = int'(last);
                m_idx[i] = 0; m_on[i] = 1; m_dv[i] = 1; m_wr[i] = 0;
            end else begin
                m_t[i]++;
                m_wr[i] = 0;
                if (m_t[i] == (m_ln[i] + 1) * dw[i]) begin
                    m_t[i] = 0; m_wr[i] = 1; m_ln[i] = int'(last);
                end
                m_idx[i] = m_t[i] / dw[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] ed;
        for (int i = 0; i < 2; i++) begin
            ed = (m_on[i] ? (8'h01 << m_idx[i]) : 8'h00) ^ INV;
            check($sformatf("D[%0d]", i),       32'(d_o[i]),   32'(ed));
            check($sformatf("d_valid[%0d]", i), 32'(dv_o[i]),  32'(m_dv[i]));
            check($sformatf("idx[%0d]", i),     32'(idx_o[i]), 32'(m_idx[i]));
            check($sformatf("wrap[%0d]", i),    32'(wr_o[i]),  32'(m_wr[i]));
        end
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    int wraps;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; a_valid = 1'b0; A = '0; last = '0;
        #12;
        check("rst_D", 32'(d_o[0]), 32'(INV));
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(2);

        // Direct decode, then hold with a_valid low
        en = 1'b1; mode = 1'b0; a_valid = 1'b1; A = 3'd6;
        cycle(1);
        check("direct_A6", 32'(d_o[0]), 32'(8'h40 ^ INV));
        a_valid = 1'b0; A = 3'd2;
        cycle(1);
        check("direct_hold", 32'(d_o[0]), 32'(8'h40 ^ INV));
        a_valid = 1'b1; A = 3'd0;
        cycle(1);
        check("direct_A0", 32'(d_o[0]), 32'(8'h01 ^ INV));
        a_valid = 1'b0;

        // Scan last=3: wrap on DWELL=4 instance exactly once in 16 cycles after entry
        mode = 1'b1; last = 3'd3;
        cycle(1);
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(1);
            if (wr_o[0]) wraps++;
        end
        check("scan4_wrap16", 32'(wr_o[0]), 32'd1);
        check("scan4_wraps", 32'(wraps), 32'd1);

        // Re-enter scan with last=7, reach idx=5 then reset asynchronously
        mode = 1'b0;
        cycle(1);
        mode = 1'b1; last = 3'd7;
        cycle(21);
        check("scan4_idx5", 32'(idx_o[0]), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_D", 32'(d_o[0]), 32'(INV));
        check("arst_idx", 32'(idx_o[0]), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(1);

        // DWELL=1 walk with last=7, change last mid-scan
        cycle(12);
        last = 3'd2;
        cycle(20);

        // en dropped while a_valid=1, then re-enable into scan
        en = 1'b0; mode = 1'b0; a_valid = 1'b1; A = 3'd4;
        cycle(1);
        check("en0_D", 32'(d_o[0]), 32'(INV));
        check("en0_dv", 32'(dv_o[0]), 32'd0);
        en = 1'b1; mode = 1'b1; a_valid = 1'b0;
        cycle(1);
        check("reen_D", 32'(d_o[0]), 32'(8'h01 ^ INV));
        check("reen_idx", 32'(idx_o[0]), 32'd0);
        cycle(10);

        // Scan with last=0
        mode = 1'b0;
        cycle(1);
        mode = 1'b1; last = 3'd0;
        cycle(12);

        // Randomised phase
        for (int k = 0; k < 600; k++) begin
            en      = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            a_valid = $urandom_range(0, 1) == 1;
            A       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) last = 3'($urandom_range(0, 7));
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
